dsp_pipe_chain: RTL and testbench
=================================

Name: dsp_pipe_chain

Overview:
- Parametrised elastic pipeline register for the DSP48A1 datapath. It is the next generation of the per-port optional input/output register.
- Provides 0..N register stages on one operand/result path, with valid/ready flow control, per-stage bubble collapsing, a clock enable, a synchronous flush and an occupancy count.
- Sits between operand sources (A, B, C, D, PCIN) and the pre-adder/multiplier/post-adder, and lets the datapath stall without dropping samples.

Parameters:
- WIDTH, 18, data width in bits (1..64).
- DEPTH, 1, number of register stages (0..8). DEPTH=0 gives a pure combinational pass-through.
- DATA_CLR, 1, when 1 the data registers clear to 0 on rst/clr; when 0 only the valid bits clear.
- OCCW, derived, occupancy width = max(1, clog2(DEPTH+1)). Not user-set.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- cen, input, 1, clock enable; when low, all stage state holds.
- clr, input, 1, synchronous flush; has priority over cen and over transfers.
- in_data, input, WIDTH, upstream data.
- in_valid, input, 1, upstream data valid.
- in_ready, output, 1, chain can accept in_data this cycle.
- out_data, output, WIDTH, data of the last stage.
- out_valid, output, 1, last stage holds valid data.
- out_ready, input, 1, downstream accepts out_data this cycle.
- occupancy, output, OCCW, number of valid stages (0..DEPTH).

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset (async assert, state released on the first clk edge after deassert):
  - all stage valid bits = 0 and occupancy = 0;
  - with DATA_CLR=1, all stage data = 0;
  - out_valid = 0 and in_ready = 0 while rst is high.
- Stage model: stages S0..S(DEPTH-1), each holding {v, d}. S0 takes input; S(DEPTH-1) drives out_data/out_valid.
- Advance conditions:
  - adv(DEPTH-1) = cen & ~clr & v(DEPTH-1) & out_ready.
  - For i < DEPTH-1: adv(i) = cen & ~clr & v(i) & (~v(i+1) | adv(i+1)).
- Load condition for stage i: load(i) = cen & ~clr & (~v(i) | adv(i)).
  - On load, S(i) takes {v(i-1), d(i-1)}; S0 takes {in_valid, in_data}.
  - A loaded invalid bubble sets v=0. Its data is loaded anyway unless DATA_CLR=1, in which case the data holds.
- Ready: in_ready = load(0). It is combinational through the chain (ready ripples from out_ready). No registered ready is required.
- Transfer occurs when in_valid & in_ready (input side) and when out_valid & out_ready (output side).
- Latency and throughput:
  - With no stalls, latency is DEPTH cycles from input transfer to out_valid.
  - Throughput is 1 sample per cycle.
  - Bubbles collapse: an empty stage is refilled even if a downstream stage is stalled.
- Backpressure: with out_ready=0, the chain fills to DEPTH samples and then in_ready=0. No sample is lost or duplicated, and order is preserved.
- cen=0:
  - no stage changes state; in_ready = 0;
  - out_valid and out_data hold, but no output transfer is counted (adv=0);
  - downstream must treat out_valid as stalled.
- clr=1 at an edge:
  - all valid bits go to 0 (and data to 0 if DATA_CLR=1), regardless of cen, in_valid or out_ready;
  - in_ready = 0 during clr, so no input is accepted that cycle;
  - the next cycle behaves as an empty chain.
- occupancy is a registered count. It is incremented on an input transfer, decremented on an output transfer, and unchanged when both occur in one cycle. It goes to 0 on clr/rst.
  - It must always equal the popcount of the stage valid bits.
- out_data when out_valid=0:
  - with DATA_CLR=1, 0 after rst/clr and otherwise the last stage register value;
  - not checked by the bench when DATA_CLR=0.
- DEPTH=0: out_data = in_data, out_valid = in_valid & ~clr, in_ready = out_ready & ~clr, occupancy = 0. There is no state, and cen is ignored.
- rst asserted mid-stream: in-flight samples are discarded immediately, without waiting for a clock edge.

Test Plan:
- DEPTH=3, WIDTH=18, out_ready=1, cen=1, stream in_data 1..10 with in_valid=1 -> out_valid rises 3 cycles after the first transfer; out_data = 1..10 on consecutive cycles; occupancy steady at 3.
- DEPTH=3, out_ready=0, stream 5 samples -> in_ready drops after 3 accepted (occupancy=3). Raise out_ready -> outputs 1,2,3 then 4,5 in order, with none lost or duplicated.
- DEPTH=4, insert a bubble (in_valid=0 for 1 cycle) while out_ready=0 -> the bubble collapses; occupancy reaches 4 with 4 valid samples; in_ready stays high until full.
- DEPTH=3, occupancy=2, assert clr together with in_valid=1 and out_ready=1 -> next cycle occupancy=0, out_valid=0, out_data=0 (DATA_CLR=1); the input sample is not accepted (in_ready=0).
- DEPTH=2, cen=0 for 3 cycles mid-stream -> stage contents, out_data and occupancy frozen; in_ready=0. After cen=1, the stream resumes with the same ordering.
- Assert rst asynchronously (between edges) with occupancy=3 -> out_valid=0 and occupancy=0 immediately. Then DEPTH=0 instance: in_data=0x2AAAA, in_valid=1, out_ready=1 -> same-cycle out_data=0x2AAAA, out_valid=1, in_ready=1.

Source files
------------

// File: rtl/dsp_pipe_chain.sv
// Elastic valid/ready register chain for one DSP48A1 operand/result path.
// Holds 0..DEPTH samples, collapses bubbles, and tracks occupancy alongside the stages.
module dsp_pipe_chain #(
   parameter int unsigned  WIDTH    = 18,
   parameter int unsigned  DEPTH    = 1,
   parameter bit           DATA_CLR = 1'b1,
   localparam int unsigned OCCW     = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cen,
   input  logic             clr,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OCCW-1:0]  occupancy
);

   if (DEPTH == 0) begin : g_pass

      // Without stages the chain is a wire; only clr still blocks the handshake.
      assign out_data  = in_data;
      assign out_valid = in_valid & ~clr;
      assign in_ready  = out_ready & ~clr;
      assign occupancy = '0;

      logic unused_pass;
      assign unused_pass = ^{clk, rst, cen};

   end else begin : g_pipe

      logic [DEPTH-1:0] v_q;
      logic [DEPTH-1:0] v_d;
      logic [WIDTH-1:0] d_q [DEPTH];
      logic [WIDTH-1:0] d_d [DEPTH];
      logic [OCCW-1:0]  occ_q;
      logic [OCCW-1:0]  occ_d;

      logic             run;
      logic [DEPTH-1:0] adv;
      logic [DEPTH-1:0] load;
      logic [DEPTH-1:0] up_v;
      logic [WIDTH-1:0] up_d [DEPTH];
      logic             in_xfer;
      logic             out_xfer;

      always_comb begin
         // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
         run      = cen & ~clr;
         adv      = '0;
         load     = '0;
         up_v     = '0;
         up_d     = d_q;
         v_d      = v_q;
         d_d      = d_q;
         occ_d    = occ_q;
         in_xfer  = 1'b0;
         out_xfer = 1'b0;

         // Ready ripples back from the output: a stage moves if its successor is empty or moving too.
         adv[DEPTH-1] = run & v_q[DEPTH-1] & out_ready;
         for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            adv[i] = run & v_q[i] & (~v_q[i+1] | adv[i+1]);
         end
         for (int i = 0; i < int'(DEPTH); i++) begin
            load[i] = run & (~v_q[i] | adv[i]);
         end

         up_v[0] = in_valid;
         up_d[0] = in_data;
         for (int i = 1; i < int'(DEPTH); i++) begin
            up_v[i] = v_q[i-1];
            up_d[i] = d_q[i-1];
         end

         in_xfer  = in_valid & load[0] & ~rst;
         out_xfer = adv[DEPTH-1];

         if (clr) begin
            v_d = '0;
            if (DATA_CLR) begin
               d_d = '{default: '0};
            end
         end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
               if (load[i]) begin
                  v_d[i] = up_v[i];
                  // A bubble keeps the old data when cleared data is promised downstream.
                  if (up_v[i] || !DATA_CLR) begin
                     d_d[i] = up_d[i];
                  end
               end
            end
         end

         if (clr) begin
            occ_d = '0;
         end else if (in_xfer && !out_xfer) begin
            occ_d = occ_q + 1'b1;
         end else if (!in_xfer && out_xfer) begin
            occ_d = occ_q - 1'b1;
         end
      end

      // NOTE: state registers use non-blocking assignments so all stages update from pre-edge values.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v_q   <= '0;
            occ_q <= '0;
         end else begin
            v_q   <= v_d;
            occ_q <= occ_d;
         end
      end

      if (DATA_CLR) begin : g_data_clr
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               d_q <= '{default: '0};
            end else begin
               d_q <= d_d;
            end
         end
      end else begin : g_data_keep
         // NOTE: data storage without reset is deliberate here; the valid bits alone qualify it.
         always_ff @(posedge clk) begin
            d_q <= d_d;
         end
      end

      assign in_ready  = load[0] & ~rst;
      assign out_data  = d_q[DEPTH-1];
      assign out_valid = v_q[DEPTH-1];
      assign occupancy = occ_q;

   end

endmodule

// File: tb/tb_dsp_pipe_chain.sv
// Scoreboard bench for dsp_pipe_chain: four depths share stimulus, one is selected at a time.
module tb_dsp_pipe_chain;

   localparam int W = 18;

   logic         clk = 1'b0;
   logic         rst;
   logic         cen;
   logic         clr;
   logic         in_valid;
   logic         out_ready;
   logic [W-1:0] in_data;
   logic [1:0]   sel;

   logic [3:0]   iv;
   logic [3:0]   ir;
   logic [3:0]   ov;
   logic [W-1:0] od [4];
   logic [3:0]   occ [4];
   logic [1:0]   occ_d3;
   logic [2:0]   occ_d4;
   logic [1:0]   occ_d2;
   logic         occ_d0;

   logic         s_ir;
   logic         s_ov;
   logic [W-1:0] s_od;
   logic [3:0]   s_occ;

   int           n_tests = 0;
   int           n_fail  = 0;
   int           idx;
   logic [W-1:0] exp_q [$];
   int           occ_t3 [7] = '{0, 1, 1, 2, 3, 4, 4};

   always #5 clk = ~clk;

   assign iv[0] = in_valid && (sel == 2'd0);
   assign iv[1] = in_valid && (sel == 2'd1);
   assign iv[2] = in_valid && (sel == 2'd2);
   assign iv[3] = in_valid && (sel == 2'd3);

   dsp_pipe_chain #(.WIDTH(W), .DEPTH(3), .DATA_CLR(1'b1)) u_d3 (
      .clk(clk), .rst(rst), .cen(cen), .clr(clr),
      .in_data(in_data), .in_valid(iv[0]), .in_ready(ir[0]),
      .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready), .occupancy(occ_d3));

   dsp_pipe_chain #(.WIDTH(W), .DEPTH(4), .DATA_CLR(1'b1)) u_d4 (
      .clk(clk), .rst(rst), .cen(cen), .clr(clr),
      .in_data(in_data), .in_valid(iv[1]), .in_ready(ir[1]),
      .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready), .occupancy(occ_d4));

   dsp_pipe_chain #(.WIDTH(W), .DEPTH(2), .DATA_CLR(1'b1)) u_d2 (
      .clk(clk), .rst(rst), .cen(cen), .clr(clr),
      .in_data(in_data), .in_valid(iv[2]), .in_ready(ir[2]),
      .out_data(od[2]), .out_valid(ov[2]), .out_ready(out_ready), .occupancy(occ_d2));

   dsp_pipe_chain #(.WIDTH(W), .DEPTH(0), .DATA_CLR(1'b1)) u_d0 (
      .clk(clk), .rst(rst), .cen(cen), .clr(clr),
      .in_data(in_data), .in_valid(iv[3]), .in_ready(ir[3]),
      .out_data(od[3]), .out_valid(ov[3]), .out_ready(out_ready), .occupancy(occ_d0));

   assign occ[0] = {2'b00, occ_d3};
   assign occ[1] = {1'b0, occ_d4};
   assign occ[2] = {2'b00, occ_d2};
   assign occ[3] = {3'b000, occ_d0};

   assign s_ir  = ir[sel];
   assign s_ov  = ov[sel];
   assign s_od  = od[sel];
   assign s_occ = occ[sel];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: accepted inputs are queued, every output transfer must match the oldest one.
   always @(negedge clk) begin
      if (!rst) begin
         if (in_valid && s_ir) begin
            exp_q.push_back(in_data);
         end
         if (s_ov && out_ready && (sel == 2'd3 || (cen && !clr))) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL out_spurious: got 0x%0h, expected no output at %0t", s_od, $time);
            end else begin
               check("out_data", s_od, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 50000");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cen = 1'b1; clr = 1'b0; in_valid = 1'b0;
      out_ready = 1'b0; in_data = '0; sel = 2'd0;
      #2;
      check("rst_out_valid", s_ov, 0);
      check("rst_in_ready", s_ir, 0);
      check("rst_occ", s_occ, 0);
      check("rst_out_data", s_od, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", s_ir, 1);
      next_cycle();

      // DEPTH=3 free-running stream 1..10
      out_ready = 1'b1;
      for (int c = 0; c < 14; c++) begin
         in_valid = (c < 10);
         in_data  = W'(c + 1);
         @(negedge clk);
         check("t1_in_ready", s_ir, 1);
         check("t1_out_valid", s_ov, (c >= 3 && c <= 12));
         check("t1_occ", s_occ, (c < 3) ? c : ((c <= 10) ? 3 : 13 - c));
         next_cycle();
      end
      check("t1_drained", exp_q.size(), 0);

      // DEPTH=3 backpressure with 5 samples
      idx = 0;
      for (int c = 0; c < 13; c++) begin
         out_ready = (c >= 6);
         in_valid  = (idx < 5);
         in_data   = W'(101 + idx);
         @(negedge clk);
         if (c < 6) begin
            check("t2_in_ready", s_ir, (c < 3));
            check("t2_occ", s_occ, (c < 3) ? c : 3);
         end
         if (c >= 3 && c < 6) check("t2_head", s_od, 101);
         if (c == 6) check("t2_ready_ripple", s_ir, 1);
         if (in_valid && s_ir) idx++;
         next_cycle();
      end
      check("t2_accepted", idx, 5);
      check("t2_drained", exp_q.size(), 0);
      check("t2_occ_end", s_occ, 0);

      // DEPTH=4 bubble collapse while stalled
      sel = 2'd1;
      idx = 0;
      for (int c = 0; c < 14; c++) begin
         out_ready = (c >= 7);
         in_valid  = (c != 1) && (idx < 5);
         in_data   = W'(201 + idx);
         @(negedge clk);
         if (c <= 6) begin
            check("t3_in_ready", s_ir, (c <= 4));
            check("t3_occ", s_occ, occ_t3[c]);
         end
         if (c == 4 || c == 6) begin
            check("t3_out_valid", s_ov, 1);
            check("t3_head", s_od, 201);
         end
         if (in_valid && s_ir) idx++;
         next_cycle();
      end
      check("t3_accepted", idx, 5);
      check("t3_drained", exp_q.size(), 0);
      check("t3_occ_end", s_occ, 0);

      // DEPTH=3 flush with occupancy 2
      sel = 2'd0;
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         in_valid = (c < 2);
         in_data  = W'(301 + c);
         @(negedge clk);
         if (c == 2) check("t4_occ_pre", s_occ, 2);
         next_cycle();
      end
      clr = 1'b1; in_valid = 1'b1; in_data = W'(303); out_ready = 1'b1;
      @(negedge clk);
      check("t4_clr_in_ready", s_ir, 0);
      next_cycle();
      exp_q.delete();
      clr = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("t4_occ", s_occ, 0);
      check("t4_out_valid", s_ov, 0);
      check("t4_out_data", s_od, 0);
      check("t4_in_ready", s_ir, 1);
      next_cycle();

      // DEPTH=2 clock-enable stall mid-stream
      sel = 2'd2;
      out_ready = 1'b1;
      idx = 0;
      for (int c = 0; c < 15; c++) begin
         cen      = !(c >= 3 && c <= 5);
         in_valid = (idx < 8);
         in_data  = W'(401 + idx);
         @(negedge clk);
         if (c >= 3 && c <= 5) begin
            check("t5_in_ready", s_ir, 0);
            check("t5_out_valid", s_ov, 1);
            check("t5_out_data", s_od, 402);
            check("t5_occ", s_occ, 2);
         end
         if (c == 6) check("t5_resume_ready", s_ir, 1);
         if (in_valid && s_ir) idx++;
         next_cycle();
      end
      cen = 1'b1;
      check("t5_accepted", idx, 8);
      check("t5_drained", exp_q.size(), 0);
      check("t5_occ_end", s_occ, 0);

      // DEPTH=3 asynchronous reset with three samples in flight
      sel = 2'd0;
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1;
         in_data  = W'(501 + c);
         @(negedge clk);
         next_cycle();
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("t6_occ_pre", s_occ, 3);
      check("t6_out_valid_pre", s_ov, 1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("t6_async_out_valid", s_ov, 0);
      check("t6_async_occ", s_occ, 0);
      check("t6_async_in_ready", s_ir, 0);
      exp_q.delete();
      next_cycle();
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check("t6_out_data", s_od, 0);
      next_cycle();

      // DEPTH=0 pass-through
      sel = 2'd3;
      in_data = 18'h2AAAA; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      check("t7_out_data", s_od, 18'h2AAAA);
      check("t7_out_valid", s_ov, 1);
      check("t7_in_ready", s_ir, 1);
      check("t7_occ", s_occ, 0);
      next_cycle();
      cen = 1'b0; in_data = 18'h15555;
      @(negedge clk);
      check("t7_cen_ignored_valid", s_ov, 1);
      check("t7_cen_ignored_ready", s_ir, 1);
      next_cycle();
      cen = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      check("t7_backpressure", s_ir, 0);
      next_cycle();
      clr = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      check("t7_clr_valid", s_ov, 0);
      check("t7_clr_ready", s_ir, 0);
      next_cycle();
      clr = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("t7_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
